ov5640_burst_wr: RTL and testbench
==================================

Name: ov5640_burst_wr

Overview:
- Downstream of the OV5640 byte-to-pixel capture stage.
- Consumes its 16-bit pixel stream (data plus one-cycle write-enable) into an internal synchronous FIFO.
- Converts the stream into fixed-length burst write requests, with a linear word address, for the SDRAM write port.
- Address wraps per frame, giving a single-frame buffer that is rewritten every frame.

Parameters:
- DATA_W, 16: pixel width (RGB565).
- FIFO_DEPTH, 512: FIFO entries. Power of 2 and at least 2*BURST_LEN.
- BURST_LEN, 64: words per burst request.
- FRAME_PIX, 307200: words per frame (640x480). Integer multiple of BURST_LEN.
- ADDR_W, 22: width of the word address.

Ports:
- sclk  in  1: clock. Pixel source and SDRAM write port are both on this clock.
- s_rst_n  in  1: reset, asynchronous assert, active-low.
- pix_data  in  DATA_W: pixel word from the capture stage.
- pix_wr_en  in  1: one-cycle strobe. pix_data is valid this cycle.
- frame_start  in  1: one-cycle pulse at the frame boundary (vsync rising edge, already frame-qualified).
- wr_req  out  1: burst request to the SDRAM controller.
- wr_addr  out  ADDR_W: burst start word address. Stable while wr_req=1.
- wr_ack  in  1: one-cycle grant of the outstanding request.
- wr_data_req  in  1: controller pulls one word per asserted cycle.
- wr_data  out  DATA_W: FIFO output word, valid the cycle after wr_data_req.
- burst_done  out  1: one-cycle pulse in the cycle after the last pull of a burst.
- fifo_level  out  log2(FIFO_DEPTH)+1: current FIFO occupancy.
- fifo_ovf  out  1: sticky. A pixel was dropped because the FIFO was full.

Behaviour:
- Reset values: wr_req=0, wr_addr=0, wr_data=0, burst_done=0, fifo_level=0, fifo_ovf=0. FIFO empty, state IDLE, burst counter 0, flush-pending flag 0.
- FIFO push: on pix_wr_en=1 when not full.
  - Push while full: word dropped, level unchanged, fifo_ovf<=1.
- FIFO pop: on wr_data_req=1 in state BURST when not empty.
  - wr_data is registered; it updates the cycle after the pop.
  - wr_data_req while empty is a protocol violation: ignored, no pop, burst counter does not advance.
- Simultaneous push and pop: level unchanged, both take effect.
- State machine IDLE -> REQ -> BURST -> IDLE:
  - IDLE: when fifo_level >= BURST_LEN, go to REQ. wr_req=1 from the next cycle.
  - REQ: wr_req held at 1 and wr_addr held until wr_ack=1. On wr_ack, go to BURST; wr_req=0 in the following cycle.
  - wr_ack while not in REQ is ignored.
  - BURST: counter counts accepted pops 0..BURST_LEN-1. On the pop with count=BURST_LEN-1:
    - counter clears, state goes to IDLE, burst_done pulses the next cycle.
    - wr_addr <= wr_addr+BURST_LEN, or 0 if wr_addr+BURST_LEN == FRAME_PIX.
  - From IDLE, a new request can be raised one cycle after returning to IDLE.
- frame_start:
  - In IDLE or REQ: next cycle the FIFO is flushed (level 0), wr_addr=0, wr_req=0, state IDLE. A pix_wr_en in the same cycle as frame_start is discarded. fifo_ovf is cleared.
  - In BURST: sets flush-pending. The burst completes normally. In the cycle the burst ends, the flush is applied and wr_addr=0 (not the incremented value). The pending flag then clears.
  - Repeated frame_start while pending: no extra effect.
- Mid-operation reset (s_rst_n low): immediate return to reset values. The in-flight burst is abandoned; the controller must also be reset.
- wr_addr is in words; byte or bank mapping is the controller's job.

Test Plan:
- Reset, then 64 pix_wr_en with data 0..63. Expect wr_req=1, wr_addr=0 the cycle after level reaches 64. Ack, then 64 pulls. Expect wr_data sequence 0..63 at one-cycle latency, burst_done one pulse, wr_addr=64, level 0.
- Push 4800 bursts (307200 words) with prompt acks. Expect wr_addr sequence 0,64,...,307136, then wrap to 0 on the next burst.
- Hold wr_ack low while pushing 520 words. Expect level saturates at 512, fifo_ovf=1, 8 words dropped, wr_req and wr_addr stable throughout.
- frame_start during REQ with level 100. Expect next cycle wr_req=0, level 0, wr_addr=0, fifo_ovf=0.
- frame_start during BURST at pull 10 with wr_addr=128. Expect the remaining 54 words delivered, burst_done pulse, then wr_addr=0 and level 0.
- Interleave pulls and pushes in the same cycles, plus one wr_data_req while empty. Expect correct data order, no pop on the empty pull, burst counter stalls and burst completes on the 64th real pop.

Source files
------------

// File: rtl/ov5640_burst_wr.sv
// ov5640_burst_wr: buffers a 16-bit pixel stream in a FIFO and issues fixed-length SDRAM burst writes
// Ports: sclk/s_rst_n clock and async active-low reset; pix_data/pix_wr_en pixel input;
// frame_start frame boundary pulse; wr_req/wr_addr/wr_ack burst request handshake;
// wr_data_req/wr_data word pull with one-cycle latency; burst_done end-of-burst pulse;
// fifo_level occupancy; fifo_ovf sticky drop flag.
module ov5640_burst_wr #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 64,
    parameter int FRAME_PIX  = 307200,
    parameter int ADDR_W     = 22
) (
    input  logic                          sclk,
    input  logic                          s_rst_n,
    input  logic [DATA_W-1:0]             pix_data,
    input  logic                          pix_wr_en,
    input  logic                          frame_start,
    output logic                          wr_req,
    output logic [ADDR_W-1:0]             wr_addr,
    input  logic                          wr_ack,
    input  logic                          wr_data_req,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          burst_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - BURST_LEN);
    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic pend, full, empty, push, pop, last, flush;
    assign full   = fifo_level == LW'(FIFO_DEPTH);
    assign empty  = fifo_level == '0;
    assign pop    = wr_data_req && state == BURST && !empty;
    assign last   = pop && cnt == CW'(BURST_LEN - 1);
    // a frame boundary seen mid-burst is deferred until the burst's final pop
    assign flush  = (frame_start && state != BURST) || (last && (pend || frame_start));
    assign push   = pix_wr_en && !full && !flush;
    assign wr_req = state == REQ;
    always_comb begin
        state_nxt = (flush || last) ? IDLE :
                    (state == IDLE && fifo_level >= LW'(BURST_LEN)) ? REQ :
                    (state == REQ && wr_ack) ? BURST : state;
    end
    always_ff @(posedge sclk) begin
        if (push) mem[wp] <= pix_data;
    end
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            burst_done <= 1'b0;
            fifo_level <= '0;
            fifo_ovf   <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst_done <= last;
            pend       <= state_nxt == BURST && (pend || frame_start);
            cnt        <= last ? '0 : cnt + CW'(pop);
            if (pop) begin
                wr_data <= mem[rp];
                rp      <= rp + 1'b1;
            end
            if (flush) begin
                wp         <= '0;
                rp         <= '0;
                fifo_level <= '0;
                fifo_ovf   <= 1'b0;
                wr_addr    <= '0;
            end else begin
                wp         <= wp + AW'(push);
                fifo_level <= fifo_level + LW'(push) - LW'(pop);
                fifo_ovf   <= fifo_ovf | (pix_wr_en & full);
                if (last) wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + ADDR_W'(BURST_LEN);
            end
        end
    end
endmodule

// File: tb/tb_ov5640_burst_wr.sv
// tb_ov5640_burst_wr: directed and random checks of ov5640_burst_wr against a queue-based model
module tb_ov5640_burst_wr;
    localparam int DW = 16, DEPTH = 512, BL = 64, FP = 1024, AW = 22;
    logic sclk = 0, s_rst_n = 0;
    logic [DW-1:0] pix_data = 0;
    logic pix_wr_en = 0, frame_start = 0, wr_ack = 0, wr_data_req = 0;
    logic wr_req, burst_done, fifo_ovf;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [9:0] fifo_level;
    int n_vec = 0, n_err = 0;

    always #5 sclk = ~sclk;

    ov5640_burst_wr #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .FRAME_PIX(FP), .ADDR_W(AW)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .pix_data(pix_data), .pix_wr_en(pix_wr_en),
        .frame_start(frame_start), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .wr_data_req(wr_data_req), .wr_data(wr_data), .burst_done(burst_done),
        .fifo_level(fifo_level), .fifo_ovf(fifo_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // model: the FIFO is a queue; the controller is described by request/burst flags
    int q[$];
    bit m_req, m_burst, m_pend, m_ovf, m_done;
    int m_addr, m_pulls;
    logic [DW-1:0] m_data = 0;

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            q.delete();
            m_req = 0; m_burst = 0; m_pend = 0; m_ovf = 0; m_done = 0;
            m_addr = 0; m_pulls = 0; m_data = 0;
        end else begin
            int lvl0;
            bit pop, last, flush, full;
            lvl0  = q.size();
            full  = lvl0 == DEPTH;
            pop   = m_burst && wr_data_req && lvl0 > 0;
            last  = pop && m_pulls == BL - 1;
            flush = (frame_start && !m_burst) || (last && (m_pend || frame_start));
            m_done = last;
            if (pop) m_data = DW'(q.pop_front());
            if (pix_wr_en && !flush && !full) q.push_back(int'(pix_data));
            if (pix_wr_en && full) m_ovf = 1;
            if (flush) begin
                q.delete();
                m_ovf = 0; m_addr = 0; m_req = 0; m_burst = 0; m_pend = 0; m_pulls = 0;
            end else if (last) begin
                m_addr  = (m_addr + BL == FP) ? 0 : m_addr + BL;
                m_burst = 0;
                m_pulls = 0;
            end else begin
                if (pop) m_pulls++;
                if (m_burst && frame_start) m_pend = 1;
                if (m_req && wr_ack) begin
                    m_req = 0;
                    m_burst = 1;
                end else if (!m_req && !m_burst && lvl0 >= BL) m_req = 1;
            end
        end
    end

    always @(negedge sclk) begin
        chk("wr_req", 32'(wr_req), 32'(m_req));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("fifo_ovf", 32'(fifo_ovf), 32'(m_ovf));
        chk("burst_done", 32'(burst_done), 32'(m_done));
        chk("wr_data", 32'(wr_data), 32'(m_data));
    end

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pix_wr_en = 1;
            pix_data = DW'(base + i);
            tick();
        end
        pix_wr_en = 0;
    endtask

    task automatic wait_req;
        int t = 0;
        while (!wr_req && t < 20) begin
            tick();
            t++;
        end
        chk("req_timeout", 32'(wr_req), 1);
    endtask

    task automatic grant;
        wr_ack = 1;
        tick();
        wr_ack = 0;
    endtask

    task automatic pull(input int n);
        for (int i = 0; i < n; i++) begin
            wr_data_req = 1;
            tick();
        end
        wr_data_req = 0;
    endtask

    task automatic fs_pull;
        frame_start = 1;
        wr_data_req = 1;
        tick();
        frame_start = 0;
        wr_data_req = 0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req", 32'(wr_req), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_data", 32'(wr_data), 0);
        s_rst_n = 1;
        tick();
        // first burst: data 0..63
        push(64, 0);
        chk("t1_level", 32'(fifo_level), 64);
        chk("t1_req_early", 32'(wr_req), 0);
        tick();
        chk("t1_req", 32'(wr_req), 1);
        chk("t1_addr", 32'(wr_addr), 0);
        grant();
        chk("t1_req_off", 32'(wr_req), 0);
        for (int i = 0; i < 64; i++) begin
            wr_data_req = 1;
            tick();
            chk("t1_data", 32'(wr_data), 32'(i));
        end
        wr_data_req = 0;
        chk("t1_done", 32'(burst_done), 1);
        chk("t1_addr_next", 32'(wr_addr), 64);
        chk("t1_level_end", 32'(fifo_level), 0);
        tick();
        chk("t1_done_off", 32'(burst_done), 0);
        // address walk across the frame and wrap
        for (int k = 0; k < 17; k++) begin
            push(64, k * 64);
            wait_req();
            chk("wrap_addr", 32'(wr_addr), 32'(((k + 1) * 64) % FP));
            grant();
            pull(64);
        end
        // overflow with request held unacknowledged
        push(520, 0);
        chk("ovf_level", 32'(fifo_level), 512);
        chk("ovf_flag", 32'(fifo_ovf), 1);
        chk("ovf_req", 32'(wr_req), 1);
        chk("ovf_addr", 32'(wr_addr), 128);
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("fs_ovf_clr", 32'(fifo_ovf), 0);
        chk("fs_addr_clr", 32'(wr_addr), 0);
        // frame_start in REQ with level 100, plus a discarded same-cycle pixel
        push(100, 0);
        wait_req();
        chk("fsreq_level", 32'(fifo_level), 100);
        frame_start = 1;
        pix_wr_en = 1;
        tick();
        frame_start = 0;
        pix_wr_en = 0;
        chk("fsreq_req", 32'(wr_req), 0);
        chk("fsreq_level0", 32'(fifo_level), 0);
        chk("fsreq_addr", 32'(wr_addr), 0);
        // frame_start at pull 10 of the burst at address 128, repeated once while pending
        for (int k = 0; k < 2; k++) begin
            push(64, 0);
            wait_req();
            grant();
            pull(64);
        end
        push(80, 500);
        wait_req();
        chk("fsb_addr", 32'(wr_addr), 128);
        grant();
        pull(9);
        fs_pull();
        chk("fsb_data10", 32'(wr_data), 509);
        pull(20);
        fs_pull();
        pull(33);
        chk("fsb_done", 32'(burst_done), 1);
        chk("fsb_data_last", 32'(wr_data), 563);
        chk("fsb_addr0", 32'(wr_addr), 0);
        chk("fsb_level0", 32'(fifo_level), 0);
        // pull while empty is ignored
        pull(1);
        chk("empty_level", 32'(fifo_level), 0);
        chk("empty_data", 32'(wr_data), 563);
        // interleaved pushes and pops inside a burst
        push(64, 1000);
        wait_req();
        grant();
        for (int i = 0; i < 64; i++) begin
            wr_data_req = 1;
            pix_wr_en = i[0];
            pix_data = DW'(2000 + i);
            tick();
            chk("mix_data", 32'(wr_data), 32'(1000 + i));
        end
        wr_data_req = 0;
        pix_wr_en = 0;
        chk("mix_done", 32'(burst_done), 1);
        chk("mix_level", 32'(fifo_level), 32);
        chk("mix_addr", 32'(wr_addr), 64);
        // random traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            pix_wr_en   = $urandom_range(0, 1) == 1;
            pix_data    = DW'($urandom);
            wr_data_req = $urandom_range(0, 4) < 3;
            wr_ack      = $urandom_range(0, 3) == 0;
            frame_start = $urandom_range(0, 199) == 0;
            s_rst_n     = !(c >= 1500 && c < 1502);
            tick();
        end
        pix_wr_en = 0; wr_data_req = 0; wr_ack = 0; frame_start = 0; s_rst_n = 1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
